calc_operand_seq: RTL and testbench
===================================

Name: calc_operand_seq

Overview:
Upstream operand-entry stage for the sign-magnitude calculator datapath. Synchronizes and debounces the raw operand, operation and "go" switches. On a debounced go press it captures A, B and the operation, computes the signed result, and holds it with a valid flag. Downstream magnitude/BCD/seven-segment stages consume its registered operands and result.

Parameters:
DEB_CYCLES, 16, consecutive stable synchronized cycles required before a debounced input changes (>=2; hardware builds use ~500000)
CNT_W, $clog2(DEB_CYCLES+1), debounce counter width (derived, not overridden)

Ports:
clk  input  1  system clock
ar  input  1  asynchronous active-low reset
aInd_in  input  1  raw sign of A (1 = negative)
a_in  input  3  raw magnitude of A
bInd_in  input  1  raw sign of B
b_in  input  3  raw magnitude of B
switchAdd  input  1  raw add-select switch
switchSub  input  1  raw subtract-select switch
go  input  1  raw capture pushbutton (active-high)
a_sm  output  4  captured A, {sign, mag}
b_sm  output  4  captured B, {sign, mag}
result  output  8  two's-complement result
res_valid  output  1  result register holds a completed computation
busy  output  1  high in EXEC state
op_err  output  1  both add and sub were set at capture

Behaviour:
- Reset is asynchronous and active-low on ar. While ar=0, every output, the state (IDLE), all debounced values, counters, sync flops and the go edge register are 0. Reset may assert in any state and aborts immediately; no pending capture survives.
- Synchronizer: every raw input (11 bits) passes through two flops.
- Debounce, per bit:
  - Counter clears whenever the synced value equals the debounced value.
  - Otherwise the counter increments. When it would reach DEB_CYCLES, the debounced value takes the synced value and the counter clears.
  - A raw level stable from edge k appears debounced at edge k+2+DEB_CYCLES.
  - Shorter glitches are discarded.
- go_rise = debounced go AND NOT its registered previous value. It is a single-cycle pulse.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: on go_rise, latch debounced operands and op, then go to EXEC.
  - EXEC (exactly 1 cycle): busy=1. Compute and register result and op_err, then go to DONE with res_valid=1.
  - DONE: result, a_sm, b_sm and op_err are held regardless of switch changes. A new go_rise re-latches and returns to EXEC; res_valid stays 1 through EXEC.
  - A go_rise during EXEC cannot occur, because go_rise is a pulse and EXEC lasts 1 cycle.
- Latency: res_valid and result update at the second edge after the edge that produces go_rise.
- Operand normalization: sign=1 with mag=0 (negative zero) is captured as 4'b0000.
- Arithmetic:
  - Each operand is converted to 5-bit two's complement (range -7..+7).
  - The op code is {sub, add}:
    - 01: A+B.
    - 10: A-B.
    - 00: 0.
    - 11: 0 with op_err=1.
  - The result range is -14..+14, sign-extended to 8 bits. Overflow is impossible.
- op_err clears on the next capture that has a legal op.

Decomposition:
- Shared package calc_pkg holds:
  - The state enum: IDLE=2'd0, EXEC=2'd1, DONE=2'd2.
  - Op codes: OP_NONE=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_ERR=2'b11.
  - Operand width constants: MAG_W=3, SM_W=4, RES_W=8.
- One sub-module, calc_debounce: 2-flop sync plus counter for a single bit, parameterized by DEB_CYCLES. It is instantiated 11 times, or once with a WIDTH parameter.

Test Plan:
- Reset: drive ar=0 while in DONE with result=8'hFE -> all outputs 0 asynchronously, before the next clk. Release ar -> state IDLE, res_valid=0.
- Add: A=+3 (0,011), B=-5 (1,101), switchAdd=1, hold, press go -> result=8'hFE, a_sm=4'h3, b_sm=4'hD, res_valid=1. busy=1 for exactly one cycle, 2 edges after go_rise.
- Sub extreme: A=-7 (1,111), B=+7 (0,111), switchSub=1, go -> result=8'hF2 (-14), op_err=0.
- Illegal op: both switches=1, A=+2, B=+2, go -> result=8'h00, op_err=1. A following go with add only -> result=8'h04, op_err=0.
- Bounce: go pulses of DEB_CYCLES-1 cycles separated by gaps of 1 cycle -> no go_rise, state stays IDLE. A pulse held for DEB_CYCLES+4 cycles -> exactly one capture.
- Negative zero and hold: A=(1,000), B=+4, sub, go -> a_sm=4'h0, result=8'hFC. Then change all switches while in DONE -> outputs unchanged until the next go.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and helpers for the sign-magnitude calculator datapath:
// FSM states, op codes, operand widths and sign-magnitude conversion.
package calc_pkg;

    localparam int MAG_W = 3;
    localparam int SM_W  = 4;
    localparam int RES_W = 8;
    localparam int TC_W  = MAG_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_ERR  = 2'b11;

    // Negative zero collapses to plain zero so downstream stages see one encoding.
    function automatic logic [SM_W-1:0] normalize_sm(input logic [SM_W-1:0] sm);
        return (sm[MAG_W-1:0] == '0) ? '0 : sm;
    endfunction

    function automatic logic signed [TC_W-1:0] sm_to_tc(input logic [SM_W-1:0] sm);
        logic signed [TC_W-1:0] mag;
        mag = {2'b00, sm[MAG_W-1:0]};
        return sm[MAG_W] ? -mag : mag;
    endfunction

endpackage

// File: rtl/calc_debounce.sv
// Two-flop synchronizer plus per-bit stability counter; a bit only changes
// after DEB_CYCLES consecutive synchronized samples disagree with it.
module calc_debounce #(
    parameter int DEB_CYCLES = 16,
    parameter int WIDTH      = 1
) (
    input  logic             clk,
    input  logic             ar,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] deb
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CNT_W-1:0] cnt;
        logic             deb_q;

        // Any sample that agrees with the current value restarts the stability window.
        always_ff @(posedge clk or negedge ar) begin
            if (!ar) begin
                cnt   <= '0;
                deb_q <= 1'b0;
            end else if (sync2[i] == deb_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb_q <= sync2[i];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign deb[i] = deb_q;
    end

endmodule

// File: rtl/calc_operand_seq.sv
// Operand-entry stage: debounces switches, captures operands on a go press,
// computes the signed result in a one-cycle EXEC state and holds it.
module calc_operand_seq
    import calc_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             ar,
    input  logic             aInd_in,
    input  logic [MAG_W-1:0] a_in,
    input  logic             bInd_in,
    input  logic [MAG_W-1:0] b_in,
    input  logic             switchAdd,
    input  logic             switchSub,
    input  logic             go,
    output logic [SM_W-1:0]  a_sm,
    output logic [SM_W-1:0]  b_sm,
    output logic [RES_W-1:0] result,
    output logic             res_valid,
    output logic             busy,
    output logic             op_err
);

    localparam int RAW_W = 2 * SM_W + 3;

    logic [RAW_W-1:0] raw_bus;
    logic [RAW_W-1:0] deb_bus;
    logic [SM_W-1:0]  a_deb;
    logic [SM_W-1:0]  b_deb;
    logic [1:0]       op_deb;
    logic             go_deb;
    logic             go_prev;
    logic             go_rise;

    assign raw_bus = {go, switchSub, switchAdd, bInd_in, b_in, aInd_in, a_in};

    calc_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .WIDTH     (RAW_W)
    ) u_debounce (
        .clk(clk),
        .ar (ar),
        .raw(raw_bus),
        .deb(deb_bus)
    );

    assign a_deb  = deb_bus[SM_W-1:0];
    assign b_deb  = deb_bus[2*SM_W-1:SM_W];
    assign op_deb = deb_bus[2*SM_W+1:2*SM_W];
    assign go_deb = deb_bus[2*SM_W+2];

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            go_prev <= 1'b0;
        end else begin
            go_prev <= go_deb;
        end
    end

    assign go_rise = go_deb & ~go_prev;

    state_t state;
    state_t state_next;
    logic   capture;
    logic   execute;

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        execute    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (go_rise) begin
                    capture    = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                execute    = 1'b1;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == EXEC);

    logic [1:0]             op_q;
    logic signed [TC_W-1:0] a_tc;
    logic signed [TC_W-1:0] b_tc;
    logic signed [TC_W-1:0] sum;
    logic [RES_W-1:0]       exec_result;
    logic                   exec_err;

    // Operands span -7..+7, so a 5-bit sum never overflows before sign extension.
    always_comb begin
        a_tc     = sm_to_tc(a_sm);
        b_tc     = sm_to_tc(b_sm);
        sum      = '0;
        exec_err = 1'b0;
        unique case (op_q)
            OP_ADD:  sum = a_tc + b_tc;
            OP_SUB:  sum = a_tc - b_tc;
            OP_ERR:  exec_err = 1'b1;
            default: sum = '0;
        endcase
        exec_result = {{(RES_W-TC_W){sum[TC_W-1]}}, sum};
    end

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            a_sm      <= '0;
            b_sm      <= '0;
            op_q      <= OP_NONE;
            result    <= '0;
            op_err    <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (capture) begin
                a_sm <= normalize_sm(a_deb);
                b_sm <= normalize_sm(b_deb);
                op_q <= op_deb;
            end
            if (execute) begin
                result    <= exec_result;
                op_err    <= exec_err;
                res_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_calc_operand_seq.sv
// Directed bench for calc_operand_seq: table of capture vectors plus
// hand-written reset, bounce and hold sequences.
module tb_calc_operand_seq;

    localparam int DEB = 4;

    logic       clk;
    logic       ar;
    logic       aInd_in;
    logic [2:0] a_in;
    logic       bInd_in;
    logic [2:0] b_in;
    logic       switchAdd;
    logic       switchSub;
    logic       go;
    logic [3:0] a_sm;
    logic [3:0] b_sm;
    logic [7:0] result;
    logic       res_valid;
    logic       busy;
    logic       op_err;

    int checks = 0;
    int errors = 0;

    calc_operand_seq #(.DEB_CYCLES(DEB)) dut (
        .clk      (clk),
        .ar       (ar),
        .aInd_in  (aInd_in),
        .a_in     (a_in),
        .bInd_in  (bInd_in),
        .b_in     (b_in),
        .switchAdd(switchAdd),
        .switchSub(switchSub),
        .go       (go),
        .a_sm     (a_sm),
        .b_sm     (b_sm),
        .result   (result),
        .res_valid(res_valid),
        .busy     (busy),
        .op_err   (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       a_sign;
        logic [2:0] a_mag;
        logic       b_sign;
        logic [2:0] b_mag;
        logic       add;
        logic       sub;
        logic [7:0] exp_result;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        aInd_in   = v.a_sign;
        a_in      = v.a_mag;
        bInd_in   = v.b_sign;
        b_in      = v.b_mag;
        switchAdd = v.add;
        switchSub = v.sub;
        go        = 1'b0;
    endtask

    // Press go after the operands have settled, then expect busy exactly DEB+3 edges later.
    task automatic run_vector(input vec_t v, input int idx);
        int n;
        apply_stimulus(v);
        tick(DEB + 4);
        go = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!busy && n < 40);
        check($sformatf("busy_latency[%0d]", idx), 8'(n), 8'(DEB + 3));
        tick(1);
        check($sformatf("busy_one_cycle[%0d]", idx), {7'd0, busy}, 8'd0);
        check($sformatf("res_valid[%0d]", idx), {7'd0, res_valid}, 8'd1);
        check($sformatf("result[%0d]", idx), result, v.exp_result);
        check($sformatf("a_sm[%0d]", idx), {4'd0, a_sm}, {4'd0, v.exp_a});
        check($sformatf("b_sm[%0d]", idx), {4'd0, b_sm}, {4'd0, v.exp_b});
        check($sformatf("op_err[%0d]", idx), {7'd0, op_err}, {7'd0, v.exp_err});
        go = 1'b0;
        tick(DEB + 4);
    endtask

    task automatic check_output(input string tag, input logic [7:0] exp_res, input logic [3:0] exp_a,
                                input logic [3:0] exp_b, input logic exp_valid, input logic exp_err);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_a_sm"}, {4'd0, a_sm}, {4'd0, exp_a});
        check({tag, "_b_sm"}, {4'd0, b_sm}, {4'd0, exp_b});
        check({tag, "_res_valid"}, {7'd0, res_valid}, {7'd0, exp_valid});
        check({tag, "_op_err"}, {7'd0, op_err}, {7'd0, exp_err});
        check({tag, "_busy"}, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        int busy_cycles;
        int early_busy;

        vecs[0] = '{1'b0, 3'd3, 1'b1, 3'd5, 1'b1, 1'b0, 8'hFE, 4'h3, 4'hD, 1'b0};
        vecs[1] = '{1'b1, 3'd7, 1'b0, 3'd7, 1'b0, 1'b1, 8'hF2, 4'hF, 4'h7, 1'b0};
        vecs[2] = '{1'b0, 3'd2, 1'b0, 3'd2, 1'b1, 1'b1, 8'h00, 4'h2, 4'h2, 1'b1};
        vecs[3] = '{1'b0, 3'd2, 1'b0, 3'd2, 1'b1, 1'b0, 8'h04, 4'h2, 4'h2, 1'b0};
        vecs[4] = '{1'b0, 3'd5, 1'b1, 3'd1, 1'b0, 1'b0, 8'h00, 4'h5, 4'h9, 1'b0};
        vecs[5] = '{1'b1, 3'd3, 1'b1, 3'd4, 1'b0, 1'b1, 8'h01, 4'hB, 4'hC, 1'b0};
        vecs[6] = '{1'b0, 3'd7, 1'b0, 3'd7, 1'b1, 1'b0, 8'h0E, 4'h7, 4'h7, 1'b0};
        vecs[7] = '{1'b1, 3'd0, 1'b0, 3'd4, 1'b0, 1'b1, 8'hFC, 4'h0, 4'h4, 1'b0};

        ar = 1'b0;
        aInd_in = 1'b0; a_in = 3'd0; bInd_in = 1'b0; b_in = 3'd0;
        switchAdd = 1'b0; switchSub = 1'b0; go = 1'b0;
        tick(3);
        check_output("reset", 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);
        ar = 1'b1;
        tick(2);

        for (int i = 0; i < 8; i++) begin
            run_vector(vecs[i], i);
        end

        $display("[TB] hold: changing all switches while in DONE");
        aInd_in = 1'b0; a_in = 3'd5; bInd_in = 1'b1; b_in = 3'd2;
        switchAdd = 1'b1; switchSub = 1'b1;
        tick(DEB + 6);
        check_output("hold", 8'hFC, 4'h0, 4'h4, 1'b1, 1'b0);

        $display("[TB] async reset from DONE");
        run_vector(vecs[0], 8);
        @(posedge clk);
        #3;
        ar = 1'b0;
        #1;
        check_output("async_reset", 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);
        tick(1);
        ar = 1'b1;
        tick(3);
        check_output("post_reset", 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);

        $display("[TB] bounce: short go pulses");
        aInd_in = 1'b0; a_in = 3'd1; bInd_in = 1'b0; b_in = 3'd1;
        switchAdd = 1'b1; switchSub = 1'b0; go = 1'b0;
        tick(DEB + 4);
        early_busy = 0;
        for (int p = 0; p < 5; p++) begin
            go = 1'b1;
            for (int c = 0; c < DEB - 1; c++) begin
                tick(1);
                if (busy || res_valid) early_busy++;
            end
            go = 1'b0;
            tick(1);
            if (busy || res_valid) early_busy++;
        end
        tick(DEB + 4);
        if (busy || res_valid) early_busy++;
        check("bounce_no_capture", 8'(early_busy), 8'd0);

        go = 1'b1;
        busy_cycles = 0;
        for (int c = 0; c < DEB + 4; c++) begin
            tick(1);
            if (busy) busy_cycles++;
        end
        go = 1'b0;
        for (int c = 0; c < 3 * DEB + 8; c++) begin
            tick(1);
            if (busy) busy_cycles++;
        end
        check("long_press_captures", 8'(busy_cycles), 8'd1);
        check_output("long_press", 8'h02, 4'h1, 4'h1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
